// File: rtl/gray_step_monitor.sv
// -----------------------------------------------------------------------------
// gray_step_monitor
//
// Consumer/checker for a W-bit Gray counter. On each Valid strobe the Gray code
// is sampled, converted to binary, and checked to be exactly one legal forward
// step from the last accepted code. Legal steps and max-to-0 wraps are counted
// (both saturating). Any illegal transition latches a sticky fault with a class
// code until Clear is asserted in FAULT.
//
// Ports:
//   Clk        in   1      rising-edge clock
//   Reset      in   1      synchronous, active-high, highest priority
//   Gray       in   W      Gray code from the upstream counter
//   Valid      in   1      sample strobe
//   Clear      in   1      leaves FAULT for IDLE (ignored in other states)
//   Bin        out  W      binary value of the last accepted Gray code
//   StepCount  out  CNT_W  legal forward steps, saturating
//   Wraps      out  8      max-to-0 steps, saturating at 255
//   Locked     out  1      high while in LOCKED
//   Error      out  1      high while in FAULT
//   ErrCode    out  2      00 none, 01 multi-bit, 10 backward, 11 jump
//   DbgState   out  2      FSM state: 0 IDLE, 1 LOCKED, 2 FAULT
//
// Handshake: Valid is a one-cycle sample qualifier with no back-pressure;
// a sample is consumed on every rising edge where Valid=1 and the FSM is in
// IDLE or LOCKED. Outputs reflect that sample after the same edge.
// -----------------------------------------------------------------------------
module gray_step_monitor #(
  parameter int W     = 3,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [W-1:0]     Gray,
  input  logic             Valid,
  input  logic             Clear,
  output logic [W-1:0]     Bin,
  output logic [CNT_W-1:0] StepCount,
  output logic [7:0]       Wraps,
  output logic             Locked,
  output logic             Error,
  output logic [1:0]       ErrCode,
  output logic [1:0]       DbgState
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_MULTI = 2'b01;
  localparam logic [1:0] EC_BACK  = 2'b10;
  localparam logic [1:0] EC_JUMP  = 2'b11;

  state_t           r_state;
  logic [W-1:0]     r_prev_g;
  logic [W-1:0]     r_bin;
  logic [CNT_W-1:0] r_step_cnt;
  logic [7:0]       r_wraps;
  logic [1:0]       r_err_code;

  state_t           w_state_nxt;
  logic [W-1:0]     w_prev_g_nxt;
  logic [W-1:0]     w_bin_nxt;
  logic [CNT_W-1:0] w_step_cnt_nxt;
  logic [7:0]       w_wraps_nxt;
  logic [1:0]       w_err_code_nxt;

  logic [W-1:0]     w_nb;
  logic [3:0]       w_diff_cnt;
  logic [W-1:0]     w_bin_inc;
  logic [W-1:0]     w_bin_dec;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits; W <= 8 so four bits are enough.
  function automatic logic [3:0] popcnt(input logic [W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    w_nb       = g2b(Gray);
    w_diff_cnt = popcnt(Gray ^ r_prev_g);
    w_bin_inc  = r_bin + W'(1);
    w_bin_dec  = r_bin - W'(1);

    w_state_nxt    = r_state;
    w_prev_g_nxt   = r_prev_g;
    w_bin_nxt      = r_bin;
    w_step_cnt_nxt = r_step_cnt;
    w_wraps_nxt    = r_wraps;
    w_err_code_nxt = r_err_code;

    case (r_state)
      ST_IDLE: begin
        // First sample only establishes the reference; it is not a step.
        if (Valid) begin
          w_prev_g_nxt = Gray;
          w_bin_nxt    = w_nb;
          w_state_nxt  = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        // An unchanged code is a stall, not an error.
        if (Valid && (w_diff_cnt != 4'd0)) begin
          if ((w_diff_cnt == 4'd1) && (w_nb == w_bin_inc)) begin
            w_prev_g_nxt = Gray;
            w_bin_nxt    = w_nb;
            if (r_step_cnt != '1) begin
              w_step_cnt_nxt = r_step_cnt + CNT_W'(1);
            end
            if ((r_bin == '1) && (w_nb == '0) && (r_wraps != 8'hFF)) begin
              w_wraps_nxt = r_wraps + 8'd1;
            end
          end else begin
            // Bin, prev_g and counters keep their last good values.
            w_state_nxt = ST_FAULT;
            if (w_diff_cnt != 4'd1) begin
              w_err_code_nxt = EC_MULTI;
            end else if (w_nb == w_bin_dec) begin
              w_err_code_nxt = EC_BACK;
            end else begin
              w_err_code_nxt = EC_JUMP;
            end
          end
        end
      end

      ST_FAULT: begin
        // Valid is ignored here, even when it coincides with Clear.
        if (Clear) begin
          w_err_code_nxt = EC_NONE;
          w_state_nxt    = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_prev_g   <= '0;
      r_bin      <= '0;
      r_step_cnt <= '0;
      r_wraps    <= '0;
      r_err_code <= EC_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_g   <= w_prev_g_nxt;
      r_bin      <= w_bin_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_wraps    <= w_wraps_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  // Locked/Error are pure decodes of the state register, so still registered.
  assign Bin       = r_bin;
  assign StepCount = r_step_cnt;
  assign Wraps     = r_wraps;
  assign Locked    = (r_state == ST_LOCKED);
  assign Error     = (r_state == ST_FAULT);
  assign ErrCode   = r_err_code;
  assign DbgState  = r_state;

endmodule

// File: tb/tb_gray_step_monitor.sv
// -----------------------------------------------------------------------------
// tb_gray_step_monitor
//
// Two instances share one input stream: u_dut (CNT_W=16) and u_dut4 (CNT_W=4,
// to reach StepCount saturation quickly). Each has a table-driven reference
// model; every cycle after the edge both DUTs are compared against their model,
// and literal expectations at scenario ends pin the model itself.
// -----------------------------------------------------------------------------
module tb_gray_step_monitor;

  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [W-1:0] gray;
  logic valid;
  logic clear;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic [W-1:0] bin16, bin4;
  logic [15:0]  step16;
  logic [3:0]   step4;
  logic [7:0]   wraps16, wraps4;
  logic         locked16, locked4, error16, error4;
  logic [1:0]   ec16, ec4, dbg16, dbg4;

  gray_step_monitor #(.W(W), .CNT_W(16)) u_dut (
    .Clk(clk), .Reset(rst), .Gray(gray), .Valid(valid), .Clear(clear),
    .Bin(bin16), .StepCount(step16), .Wraps(wraps16), .Locked(locked16),
    .Error(error16), .ErrCode(ec16), .DbgState(dbg16)
  );

  gray_step_monitor #(.W(W), .CNT_W(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Gray(gray), .Valid(valid), .Clear(clear),
    .Bin(bin4), .StepCount(step4), .Wraps(wraps4), .Locked(locked4),
    .Error(error4), .ErrCode(ec4), .DbgState(dbg4)
  );

  // ---------------- reference model ----------------
  // st: 0 idle, 1 locked, 2 fault
  typedef struct {
    int st;
    int bin;
    int prev_g;
    int step;
    int wraps;
    int ec;
  } model_t;

  model_t m16, m4;

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  // Decode by searching the Gray sequence rather than by XOR chain.
  function automatic int decode(input int g);
    for (int n = 0; n < (1 << W); n++) begin
      if (gray_of(n) == g) return n;
    end
    return -1;
  endfunction

  function automatic model_t model_next(input model_t m, input logic r,
                                        input int g, input logic v,
                                        input logic c, input int cnt_max);
    model_t n;
    int     d;
    int     nb;
    logic [W-1:0] x;
    n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 0, 0};
      return n;
    end
    x  = W'(g ^ m.prev_g);
    d  = $countones(x);
    nb = decode(g);
    case (m.st)
      0: if (v) begin
        n.prev_g = g;
        n.bin    = nb;
        n.st     = 1;
      end
      1: if (v && d != 0) begin
        if (d == 1 && nb == (m.bin + 1) % (1 << W)) begin
          n.prev_g = g;
          n.bin    = nb;
          if (m.step < cnt_max) n.step = m.step + 1;
          if (nb == 0 && m.wraps < 255) n.wraps = m.wraps + 1;
        end else begin
          n.st = 2;
          if (d >= 2)                                      n.ec = 1;
          else if (nb == (m.bin + (1 << W) - 1) % (1 << W)) n.ec = 2;
          else                                             n.ec = 3;
        end
      end
      2: if (c) begin
        n.ec = 0;
        n.st = 0;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  initial begin
    m16 = '{0, 0, 0, 0, 0, 0};
    m4  = '{0, 0, 0, 0, 0, 0};
  end

  always @(posedge clk) begin
    m16 = model_next(m16, rst, int'(gray), valid, clear, 65535);
    m4  = model_next(m4,  rst, int'(gray), valid, clear, 15);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Outputs change only on posedge; compare at negedge.
  always @(negedge clk) begin
    chk("bin16",    32'(bin16),    32'(m16.bin));
    chk("step16",   32'(step16),   32'(m16.step));
    chk("wraps16",  32'(wraps16),  32'(m16.wraps));
    chk("locked16", 32'(locked16), 32'(m16.st == 1));
    chk("error16",  32'(error16),  32'(m16.st == 2));
    chk("ec16",     32'(ec16),     32'(m16.ec));
    chk("bin4",     32'(bin4),     32'(m4.bin));
    chk("step4",    32'(step4),    32'(m4.step));
    chk("wraps4",   32'(wraps4),   32'(m4.wraps));
    chk("locked4",  32'(locked4),  32'(m4.st == 1));
    chk("error4",   32'(error4),   32'(m4.st == 2));
    chk("ec4",      32'(ec4),      32'(m4.ec));
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] g, input logic v,
                       input logic c, input logic r);
    gray  = g;
    valid = v;
    clear = c;
    rst   = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(3'b000, 1'b0, 1'b0, 1'b1);
    drive(3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  logic [W-1:0] seq [9];

  initial begin
    gray = '0; valid = 1'b0; clear = 1'b0; rst = 1'b1;

    // Reset values
    do_reset();
    chk("lit_reset_bin",    32'(bin16),    32'd0);
    chk("lit_reset_step",   32'(step16),   32'd0);
    chk("lit_reset_locked", 32'(locked16), 32'd0);
    chk("lit_reset_error",  32'(error16),  32'd0);
    chk("lit_reset_ec",     32'(ec16),     32'd0);

    // Full forward cycle with a wrap
    seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
            3'b111, 3'b101, 3'b100, 3'b000};
    drive(seq[0], 1'b1, 1'b0, 1'b0);
    chk("lit_lock_first", 32'(locked16), 32'd1);
    for (int i = 1; i < 9; i++) drive(seq[i], 1'b1, 1'b0, 1'b0);
    chk("lit_cycle_bin",   32'(bin16),   32'd0);
    chk("lit_cycle_step",  32'(step16),  32'd8);
    chk("lit_cycle_wraps", 32'(wraps16), 32'd1);
    chk("lit_cycle_error", 32'(error16), 32'd0);

    // Backward step: lock at 011 (bin 2), then 001
    do_reset();
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    chk("lit_back_error",  32'(error16),  32'd1);
    chk("lit_back_ec",     32'(ec16),     32'd2);
    chk("lit_back_locked", 32'(locked16), 32'd0);
    chk("lit_back_bin",    32'(bin16),    32'd2);
    chk("lit_back_step",   32'(step16),   32'd0);
    // Valid in FAULT is ignored
    drive(3'b010, 1'b1, 1'b0, 1'b0);
    chk("lit_fault_frozen", 32'(bin16), 32'd2);

    // Non-adjacent jump: lock at 001 (bin 1), then 101 (bin 6)
    do_reset();
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    drive(3'b101, 1'b1, 1'b0, 1'b0);
    chk("lit_jump_ec", 32'(ec16), 32'd3);

    // Multi-bit change, Clear with Valid, then relock
    do_reset();
    drive(3'b000, 1'b1, 1'b0, 1'b0);
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    drive(3'b010, 1'b1, 1'b0, 1'b0);
    chk("lit_multi_ec", 32'(ec16), 32'd1);
    drive(3'b110, 1'b1, 1'b1, 1'b0);
    chk("lit_clear_error",  32'(error16),  32'd0);
    chk("lit_clear_ec",     32'(ec16),     32'd0);
    chk("lit_clear_locked", 32'(locked16), 32'd0);
    chk("lit_clear_step",   32'(step16),   32'd1);
    drive(3'b110, 1'b1, 1'b0, 1'b0);
    chk("lit_relock_locked", 32'(locked16), 32'd1);
    chk("lit_relock_bin",    32'(bin16),    32'd4);
    drive(3'b110, 1'b0, 1'b1, 1'b0);
    chk("lit_clear_in_locked", 32'(locked16), 32'd1);

    // Stalls and unqualified changes, then one legal step
    for (int i = 0; i < 3; i++) drive(3'b110, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    drive(3'b011, 1'b0, 1'b0, 1'b0);
    chk("lit_stall_step", 32'(step16), 32'd1);
    drive(3'b111, 1'b1, 1'b0, 1'b0);
    chk("lit_after_stall_step", 32'(step16), 32'd2);
    chk("lit_after_stall_bin",  32'(bin16),  32'd5);

    // Fault, then Reset with Clear and Valid together
    drive(3'b000, 1'b1, 1'b0, 1'b0);
    chk("lit_pre_reset_error", 32'(error16), 32'd1);
    drive(3'b001, 1'b1, 1'b1, 1'b1);
    chk("lit_rst_fault_error", 32'(error16), 32'd0);
    chk("lit_rst_fault_step",  32'(step16),  32'd0);
    chk("lit_rst_fault_bin",   32'(bin16),   32'd0);

    // StepCount saturation on the CNT_W=4 instance
    drive(3'b000, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) drive(W'(gray_of(k % 8)), 1'b1, 1'b0, 1'b0);
    chk("lit_sat_step4",  32'(step4),  32'd15);
    chk("lit_sat_wraps4", 32'(wraps4), 32'd2);
    chk("lit_sat_step16", 32'(step16), 32'd20);
    chk("lit_sat_bin",    32'(bin16),  32'd4);

    // Wraps saturation at 255
    do_reset();
    drive(3'b000, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 2048 + 8; k++) drive(W'(gray_of(k % 8)), 1'b1, 1'b0, 1'b0);
    chk("lit_wraps_sat",  32'(wraps16), 32'd255);
    chk("lit_wraps_step", 32'(step16),  32'd2056);

    drive(3'b000, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
